ula_arbitro: RTL and testbench

Time-shares a single ULA instance between two requesters (e.g. the datapath execute stage and the address/branch unit). Each request is accepted through a valid/ready handshake. The block then drives the ULA operand and opcode inputs, captures RESU and the O/C/S/Z flags one cycle later, and returns them to the winning requester through a valid/ready response channel. Arbitration is round-robin. The ULA itself is instantiated outside this block, in the parent.

---
 rtl/ula_arbitro.sv | 155 +++++++++++++++
 tb/tb_ula_arbitro.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_arbitro.sv
// Round-robin arbiter that time-shares one external ULA between two requesters.
// Define ULA_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module ula_arbitro #(
    parameter int BITS = 3,
    parameter int OPW  = 5,
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [BITS-1:0] req_A0,
    input  logic [BITS-1:0] req_B0,
    input  logic [BITS-1:0] req_A1,
    input  logic [BITS-1:0] req_B1,
    input  logic [OPW-1:0]  req_op0,
    input  logic [OPW-1:0]  req_op1,
    output logic [BITS-1:0] ula_A,
    output logic [BITS-1:0] ula_B,
    output logic [OPW-1:0]  ula_OP,
    input  logic [BITS-1:0] ula_RESU,
    input  logic            ula_O,
    input  logic            ula_C,
    input  logic            ula_S,
    input  logic            ula_Z,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            resp_id,
    output logic [BITS-1:0] resp_result,
    output logic [3:0]      resp_flags,
    output logic [CNTW-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] ula_a_q, ula_a_d;
    logic [BITS-1:0] ula_b_q, ula_b_d;
    logic [OPW-1:0]  ula_op_q, ula_op_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_id_q, resp_id_d;
    logic [BITS-1:0] resp_result_q, resp_result_d;
    logic [3:0]      resp_flags_q, resp_flags_d;
    logic [CNTW-1:0] ops_done_q, ops_done_d;
    logic            rr_ptr;
    logic            grant_any;
    logic            grant_id;

`ifdef ULA_ARB_FIXED_PRIO_EN
    assign rr_ptr = 1'b0;
`else
    logic rr_ptr_q, rr_ptr_d;
    assign rr_ptr = rr_ptr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= 1'b0;
        else        rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
        case (req_valid)
            2'b01:   begin grant_any = 1'b1; grant_id = 1'b0;   end
            2'b10:   begin grant_any = 1'b1; grant_id = 1'b1;   end
            2'b11:   begin grant_any = 1'b1; grant_id = rr_ptr; end
            default: begin grant_any = 1'b0; grant_id = 1'b0;   end
        endcase
        req_ready = 2'b00;
        if (rst_n && state_q == IDLE && grant_any) req_ready[grant_id] = 1'b1;
    end

    always_comb begin
        state_d       = state_q;
        ula_a_d       = ula_a_q;
        ula_b_d       = ula_b_q;
        ula_op_d      = ula_op_q;
        resp_valid_d  = resp_valid_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        resp_flags_d  = resp_flags_q;
        ops_done_d    = ops_done_q;
`ifndef ULA_ARB_FIXED_PRIO_EN
        rr_ptr_d      = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    ula_a_d   = grant_id ? req_A1  : req_A0;
                    ula_b_d   = grant_id ? req_B1  : req_B0;
                    ula_op_d  = grant_id ? req_op1 : req_op0;
                    resp_id_d = grant_id;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                resp_result_d = ula_RESU;
                resp_flags_d  = {ula_O, ula_C, ula_S, ula_Z};
                resp_valid_d  = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    ops_done_d   = ops_done_q + 1'b1;
`ifndef ULA_ARB_FIXED_PRIO_EN
                    // last winner drops to lowest priority
                    rr_ptr_d     = ~resp_id_q;
`endif
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ula_a_q       <= '0;
            ula_b_q       <= '0;
            ula_op_q      <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            ops_done_q    <= '0;
        end else begin
            state_q       <= state_d;
            ula_a_q       <= ula_a_d;
            ula_b_q       <= ula_b_d;
            ula_op_q      <= ula_op_d;
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
            resp_flags_q  <= resp_flags_d;
            ops_done_q    <= ops_done_d;
        end
    end

    assign ula_A       = ula_a_q;
    assign ula_B       = ula_b_q;
    assign ula_OP      = ula_op_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_flags  = resp_flags_q;
    assign ops_done    = ops_done_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// Bench for ula_arbitro: a small ULA stub plus a transaction-level model of
// arbitration, latency, backpressure, reset and the completion counter.
module tb_ula_arbitro;

`ifdef ULA_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [2:0] req_A0, req_B0, req_A1, req_B1;
    logic [4:0] req_op0, req_op1;
    logic [2:0] ula_A, ula_B;
    logic [4:0] ula_OP;
    logic [2:0] ula_RESU;
    logic       ula_O, ula_C, ula_S, ula_Z;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_id;
    logic [2:0] resp_result;
    logic [3:0] resp_flags;
    logic [7:0] ops_done;

    int checks = 0;
    int errors = 0;

    // model state
    logic       pri;
    int         exp_cnt;
    int         completions;
    logic       last_id_obs;
    logic [2:0] last_res_obs;
    logic [3:0] last_flags_obs;

    always #5 clk = ~clk;

    ula_arbitro dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A0(req_A0), .req_B0(req_B0), .req_A1(req_A1), .req_B1(req_B1),
        .req_op0(req_op0), .req_op1(req_op1),
        .ula_A(ula_A), .ula_B(ula_B), .ula_OP(ula_OP),
        .ula_RESU(ula_RESU), .ula_O(ula_O), .ula_C(ula_C), .ula_S(ula_S), .ula_Z(ula_Z),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flags(resp_flags), .ops_done(ops_done)
    );

    // ULA stub: op[1:0] = add, sub, and, xor; returns {O,C,S,Z,RESU}
    function automatic logic [6:0] ula_ref(input logic [2:0] a, input logic [2:0] b,
                                           input logic [4:0] op);
        int ua, ub, sa, sb, r, sr;
        logic c, o;
        logic [2:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = a[2] ? ua - 8 : ua;
        sb = b[2] ? ub - 8 : ub;
        c = 1'b0;
        o = 1'b0;
        r = 0;
        case (op[1:0])
            2'd0: begin r = ua + ub; c = (r > 7);   sr = sa + sb; o = (sr > 3) || (sr < -4); end
            2'd1: begin r = ua - ub; c = (ua < ub); sr = sa - sb; o = (sr > 3) || (sr < -4); end
            2'd2: r = int'(a & b);
            default: r = int'(a ^ b);
        endcase
        res = r[2:0];
        return {o, c, res[2], (res == 3'd0), res};
    endfunction

    always_comb begin
        logic [6:0] u;
        u = ula_ref(ula_A, ula_B, ula_OP);
        {ula_O, ula_C, ula_S, ula_Z, ula_RESU} = u;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] model_grant(input logic [1:0] v);
        // returns {any, id}
        case (v)
            2'b01:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return {1'b1, FIXED ? 1'b0 : pri};
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        pri     = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // Caller guarantees the DUT is idle, #1 after an edge, resp_ready low.
    task automatic do_txn(input logic [1:0] v,
                          input logic [2:0] a0, input logic [2:0] b0, input logic [4:0] o0,
                          input logic [2:0] a1, input logic [2:0] b1, input logic [4:0] o1,
                          input int stall);
        logic [1:0] g;
        logic [2:0] ea, eb, er;
        logic [4:0] eo;
        logic [3:0] ef;
        logic [6:0] u;
        req_valid = v;
        req_A0 = a0; req_B0 = b0; req_op0 = o0;
        req_A1 = a1; req_B1 = b1; req_op1 = o1;
        #1;
        g = model_grant(v);
        chk("req_ready_idle", 32'(req_ready), g[1] ? (g[0] ? 32'h2 : 32'h1) : 32'h0);
        @(posedge clk); #1;
        if (!g[1]) begin
            req_valid = 2'b00;
            return;
        end
        ea = g[0] ? a1 : a0;
        eb = g[0] ? b1 : b0;
        eo = g[0] ? o1 : o0;
        chk("ula_A", 32'(ula_A), 32'(ea));
        chk("ula_B", 32'(ula_B), 32'(eb));
        chk("ula_OP", 32'(ula_OP), 32'(eo));
        chk("resp_valid_exec", 32'(resp_valid), 32'h0);
        chk("req_ready_exec", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        u  = ula_ref(ea, eb, eo);
        ef = u[6:3];
        er = u[2:0];
        chk("resp_valid", 32'(resp_valid), 32'h1);
        chk("resp_id", 32'(resp_id), 32'(g[0]));
        chk("resp_result", 32'(resp_result), 32'(er));
        chk("resp_flags", 32'(resp_flags), 32'(ef));
        chk("ops_done_resp", 32'(ops_done), 32'(exp_cnt % 256));
        last_id_obs    = resp_id;
        last_res_obs   = resp_result;
        last_flags_obs = resp_flags;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk("bp_valid", 32'(resp_valid), 32'h1);
            chk("bp_result", 32'(resp_result), 32'(er));
            chk("bp_flags", 32'(resp_flags), 32'(ef));
            chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_ops_done", 32'(ops_done), 32'(exp_cnt % 256));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 2'b00;
        exp_cnt++;
        completions++;
        pri = ~g[0];
        chk("resp_valid_done", 32'(resp_valid), 32'h0);
        chk("ops_done", 32'(ops_done), 32'(exp_cnt % 256));
    endtask

    initial begin
        logic [1:0] v;
        logic [2:0] ra0, rb0, ra1, rb1;
        logic [4:0] ro0, ro1;
        int iter;

        completions = 0;
        req_A0 = '0; req_B0 = '0; req_A1 = '0; req_B1 = '0;
        req_op0 = '0; req_op1 = '0;

        // reset values, with both requesters asserting during reset
        rst_n = 1'b0; resp_ready = 1'b0; req_valid = 2'b11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_ula_A", 32'(ula_A), 32'h0);
        chk("rst_ula_B", 32'(ula_B), 32'h0);
        chk("rst_ula_OP", 32'(ula_OP), 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);
        chk("rst_resp_result", 32'(resp_result), 32'h0);
        chk("rst_resp_flags", 32'(resp_flags), 32'h0);
        chk("rst_ops_done", 32'(ops_done), 32'h0);
        req_valid = 2'b00;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;

        // single requester: 1 + 7 -> 000 with C and Z
        do_txn(2'b01, 3'b001, 3'b111, 5'b00000, 3'b000, 3'b000, 5'b00000, 0);
        chk("tp1_id", 32'(last_id_obs), 32'h0);
        chk("tp1_res", 32'(last_res_obs), 32'h0);
        chk("tp1_flags", 32'(last_flags_obs), 32'b0101);
        chk("tp1_ops", 32'(ops_done), 32'h1);

        // contention from reset
        do_reset();
        do_txn(2'b11, 3'b010, 3'b011, 5'd0, 3'b001, 3'b010, 5'd0, 0);
        chk("tp2_id0", 32'(last_id_obs), 32'h0);
        chk("tp2_res0", 32'(last_res_obs), 32'b101);
        chk("tp2_flags0", 32'(last_flags_obs), 32'b1010);
        do_txn(2'b11, 3'b010, 3'b011, 5'd0, 3'b001, 3'b010, 5'd0, 0);
        chk("tp2_id1", 32'(last_id_obs), FIXED ? 32'h0 : 32'h1);
        chk("tp2_res1", 32'(last_res_obs), FIXED ? 32'b101 : 32'b011);
        do_txn(2'b11, 3'b010, 3'b011, 5'd0, 3'b001, 3'b010, 5'd0, 0);
        chk("tp2_id2", 32'(last_id_obs), 32'h0);
        do_txn(2'b11, 3'b010, 3'b011, 5'd0, 3'b001, 3'b010, 5'd0, 0);
        chk("tp2_id3", 32'(last_id_obs), FIXED ? 32'h0 : 32'h1);

        // backpressure with both requesters valid
        do_txn(2'b11, 3'b110, 3'b011, 5'd1, 3'b101, 3'b100, 5'd2, 5);

        // reset in EXEC after requester 0 last won
        do_reset();
        do_txn(2'b01, 3'b011, 3'b001, 5'd3, 3'b000, 3'b000, 5'd0, 0);
        req_valid = 2'b11;
        req_A0 = 3'b100; req_B0 = 3'b001; req_op0 = 5'd0;
        req_A1 = 3'b111; req_B1 = 3'b110; req_op1 = 5'd1;
        #1;
        chk("mid_req_ready", 32'(req_ready), FIXED ? 32'h1 : 32'h2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_resp_valid", 32'(resp_valid), 32'h0);
        chk("mid_ula_A", 32'(ula_A), 32'h0);
        chk("mid_ula_B", 32'(ula_B), 32'h0);
        chk("mid_ula_OP", 32'(ula_OP), 32'h0);
        chk("mid_ops_done", 32'(ops_done), 32'h0);
        chk("mid_req_ready_rst", 32'(req_ready), 32'h0);
        rst_n = 1'b1;
        req_valid = 2'b00;
        model_reset();
        do_txn(2'b11, 3'b001, 3'b001, 5'd0, 3'b010, 3'b010, 5'd0, 0);
        chk("mid_rr_restart", 32'(last_id_obs), 32'h0);

        // randomized traffic up to counter wrap
        do_reset();
        completions = 0;
        iter = 0;
        while (completions < 256 && iter < 2000) begin
            v   = 2'($urandom_range(0, 3));
            ra0 = 3'($urandom); rb0 = 3'($urandom); ro0 = 5'($urandom);
            ra1 = 3'($urandom); rb1 = 3'($urandom); ro1 = 5'($urandom);
            do_txn(v, ra0, rb0, ro0, ra1, rb1, ro1, ($urandom_range(0, 7) == 0) ? 2 : 0);
            iter++;
        end
        chk("wrap_completions", 32'(completions), 32'd256);
        chk("wrap_ops_done", 32'(ops_done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
